// File: rtl/fft_frame_ctrl.sv
// Frame sequencer wrapped around a streaming FFT core. It sends one config
// word, waits a fixed settle time, then feeds exactly N = 2^L beats into the
// core, zero-padding short frames and dropping the tail of long ones. The
// core output is forwarded with a bin index and length checking.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; all streams quiet
// CONFIG  | config word presented to the core until accepted
// WAIT    | fixed CONFIG_LATENCY cycle settle after config accept
// WR      | input samples passed through to the core
// ZP      | short input frame: zero beats sent until N beats total
// DISCARD | long input frame: extra input beats dropped up to tlast
// RD      | core output passed through to m_axis with bin index
module fft_frame_ctrl #(
  parameter int MAX_LOG2_LEN   = 13,
  parameter int CHANNELS       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int CONFIG_LATENCY = 16,
  parameter int INDEX_WIDTH    = 32
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           start,
  input  logic [4:0]                     cfg_log2_len,
  input  logic                           cfg_inverse,
  input  logic                           clear_err,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [15:0]                    m_fft_cfg_tdata,
  output logic                           m_fft_cfg_tvalid,
  input  logic                           m_fft_cfg_tready,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_fft_data_tdata,
  output logic                           m_fft_data_tvalid,
  output logic                           m_fft_data_tlast,
  input  logic                           m_fft_data_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_fft_data_tdata,
  input  logic                           s_fft_data_tvalid,
  input  logic                           s_fft_data_tlast,
  output logic                           s_fft_data_tready,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic [INDEX_WIDTH-1:0]         m_index,
  output logic                           busy,
  output logic [15:0]                    frame_count,
  output logic                           err_truncated,
  output logic                           err_len
);

  localparam int DW       = CHANNELS * DATA_WIDTH;
  localparam int CW       = MAX_LOG2_LEN + 1;
  localparam int LATW     = (CONFIG_LATENCY > 1) ? $clog2(CONFIG_LATENCY) : 1;
  localparam int LAT_LOAD = (CONFIG_LATENCY > 0) ? CONFIG_LATENCY - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_WAIT, S_WR, S_ZP, S_DISCARD, S_RD
  } state_t;

  state_t                 state_q, state_d;
  logic [4:0]             log2_q, log2_d;
  logic                   inv_q, inv_d;
  logic [CW-1:0]          remaining_q, remaining_d;
  logic [LATW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   err_trunc_q, err_trunc_d;
  logic                   err_len_q, err_len_d;
  logic                   set_trunc, set_len;
  logic [4:0]             len_clamped;
  logic [CW-1:0]          n_full, n_last;
  logic                   at_last_bin;
  logic                   rst_meta_q, rst_sync_q;

  // Reset asserts immediately, releases two clocks after aresetn rises.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Requested length exponent limited to the range the core supports.
  always_comb begin
    len_clamped = cfg_log2_len;
    if (cfg_log2_len < 5'd3)
      len_clamped = 5'd3;
    else if (cfg_log2_len > 5'(MAX_LOG2_LEN))
      len_clamped = 5'(MAX_LOG2_LEN);
  end

  assign n_full      = CW'(1) << log2_q;
  assign n_last      = n_full - CW'(1);
  assign at_last_bin = (index_q == INDEX_WIDTH'(n_last));

  // State register and all counters/flags.
  always_ff @(posedge aclk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q       <= S_IDLE;
      log2_q        <= '0;
      inv_q         <= 1'b0;
      remaining_q   <= '0;
      wait_cnt_q    <= '0;
      index_q       <= '0;
      frame_count_q <= '0;
      err_trunc_q   <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      log2_q        <= log2_d;
      inv_q         <= inv_d;
      remaining_q   <= remaining_d;
      wait_cnt_q    <= wait_cnt_d;
      index_q       <= index_d;
      frame_count_q <= frame_count_d;
      err_trunc_q   <= err_trunc_d;
      err_len_q     <= err_len_d;
    end
  end

  // Next-state, counter updates and stream muxing per state.
  always_comb begin
    state_d           = state_q;
    log2_d            = log2_q;
    inv_d             = inv_q;
    remaining_d       = remaining_q;
    wait_cnt_d        = wait_cnt_q;
    index_d           = index_q;
    frame_count_d     = frame_count_q;
    set_trunc         = 1'b0;
    set_len           = 1'b0;
    s_axis_tready     = 1'b0;
    m_fft_cfg_tdata   = '0;
    m_fft_cfg_tvalid  = 1'b0;
    m_fft_data_tdata  = '0;
    m_fft_data_tvalid = 1'b0;
    m_fft_data_tlast  = 1'b0;
    s_fft_data_tready = 1'b0;
    m_axis_tdata      = '0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;

    case (state_q)
      S_IDLE: begin
        index_d = '0;
        if (start) begin
          state_d = S_CONFIG;
          log2_d  = len_clamped;
          inv_d   = cfg_inverse;
        end
      end

      S_CONFIG: begin
        m_fft_cfg_tvalid = 1'b1;
        m_fft_cfg_tdata  = {7'b0, ~inv_q, 3'b0, log2_q};
        if (m_fft_cfg_tready) begin
          state_d    = S_WAIT;
          wait_cnt_d = LATW'(LAT_LOAD);
        end
      end

      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d     = S_WR;
          remaining_d = n_full;
        end else begin
          wait_cnt_d = wait_cnt_q - LATW'(1);
        end
      end

      S_WR: begin
        m_fft_data_tdata  = s_axis_tdata;
        m_fft_data_tvalid = s_axis_tvalid;
        m_fft_data_tlast  = (remaining_q == CW'(1));
        s_axis_tready     = m_fft_data_tready;
        if (s_axis_tvalid && m_fft_data_tready) begin
          remaining_d = remaining_q - CW'(1);
          if (s_axis_tlast) begin
            state_d = (remaining_q > CW'(1)) ? S_ZP : S_RD;
          end else if (remaining_q == CW'(1)) begin
            state_d   = S_DISCARD;
            set_trunc = 1'b1;
          end
        end
      end

      S_ZP: begin
        m_fft_data_tvalid = 1'b1;
        m_fft_data_tlast  = (remaining_q == CW'(1));
        if (m_fft_data_tready) begin
          remaining_d = remaining_q - CW'(1);
          if (remaining_q == CW'(1))
            state_d = S_RD;
        end
      end

      S_DISCARD: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast)
          state_d = S_RD;
      end

      S_RD: begin
        m_axis_tdata      = s_fft_data_tdata;
        m_axis_tvalid     = s_fft_data_tvalid;
        m_axis_tlast      = s_fft_data_tlast;
        s_fft_data_tready = m_axis_tready;
        if (s_fft_data_tvalid && m_axis_tready) begin
          index_d = index_q + INDEX_WIDTH'(1);
          if (s_fft_data_tlast) begin
            set_len       = !at_last_bin;
            state_d       = S_IDLE;
            index_d       = '0;
            frame_count_d = frame_count_q + 16'd1;
          end else if (at_last_bin) begin
            set_len = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    err_trunc_d = set_trunc | (err_trunc_q & ~clear_err);
    err_len_d   = set_len   | (err_len_q   & ~clear_err);
  end

  assign busy          = (state_q != S_IDLE);
  assign m_index       = index_q;
  assign frame_count   = frame_count_q;
  assign err_truncated = err_trunc_q;
  assign err_len       = err_len_q;

endmodule
